// File: rtl/pllsup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding,
// loss counter width, RUN-state deglitch length and a counter-width helper.
// No ports; imported by the interface, the synchroniser and the top.
package pllsup_pkg;

  // Encoding is visible on the state output and read by software.
  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pllsup_state_e;

  localparam int LOSS_W       = 8;
  localparam int DEGLITCH_LEN = 4;

  // A counter that must hold values up to 'limit' without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// master: supervisor side (drives pll_rst, sys_reset, ready, state, loss_count;
//         receives pll_locked, force_relock). slave: PLL/system side.
interface pllsup_if;
  import pllsup_pkg::*;

  logic              pll_locked;    // asynchronous PLL lock flag
  logic              force_relock;  // single-cycle re-sequence request
  logic              pll_rst;       // active-high PLL reset
  logic              sys_reset;     // active-high reset for PLL-clocked logic
  logic              ready;         // high while in RUN
  logic [1:0]        state;         // current FSM state
  logic [LOSS_W-1:0] loss_count;    // saturating lock-loss count

  modport master (
    input  pll_locked, force_relock,
    output pll_rst, sys_reset, ready, state, loss_count
  );

  modport slave (
    output pll_locked, force_relock,
    input  pll_rst, sys_reset, ready, state, loss_count
  );

endinterface

// File: rtl/pllsup_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports: clk_i/rst_n_i (async active-low, flops clear to 0), d_i async input,
// q_o = d_i delayed through SYNC_STAGES flops.
module pllsup_sync
  import pllsup_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the reference clock: pulses the PLL reset, waits for
// a stable synchronised lock, then releases sys_reset; re-sequences on lock
// timeout or force_relock and counts lock losses seen in RUN.
// Ports: refclk, rst_n (async active-low); bus (pllsup_if.master) carries
// pll_locked/force_relock in and pll_rst/sys_reset/ready/state/loss_count out.
// All outputs are registered; state changes appear on the edge after the cause.
// Build option: define PLLSUP_DEGLITCH_EN to require DEGLITCH_LEN consecutive
// unlocked cycles before RUN declares a lock loss.
module pll_lock_supervisor
  import pllsup_pkg::*;
#(
  parameter int STABLE_CYCLES  = 65536,
  parameter int LOCK_TIMEOUT   = 5000000,
  parameter int PLL_RST_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic     refclk,
  input  logic     rst_n,
  pllsup_if.master bus
);

  localparam logic [1:0] S_PLLRST = PLLRST;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_STABLE = STABLE;
  localparam logic [1:0] S_RUN    = RUN;

  localparam int RST_W = cnt_width(PLL_RST_CYCLES);
  localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W = cnt_width(STABLE_CYCLES);

  logic              locked_s;
  logic [1:0]        state_q,   state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;
  logic [STB_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [LOSS_W-1:0] loss_q,    loss_d;
  logic              pll_rst_q, sys_reset_q, ready_q;
  logic              lock_drop;

  pllsup_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (refclk),
    .rst_n_i (rst_n),
    .d_i     (bus.pll_locked),
    .q_o     (locked_s)
  );

`ifdef PLLSUP_DEGLITCH_EN
  localparam int DG_W = cnt_width(DEGLITCH_LEN);

  logic [DG_W-1:0] dg_cnt_q, dg_cnt_d;

  // Counts consecutive unlocked cycles in RUN; a loss is declared on the
  // DEGLITCH_LEN-th one, shorter dips are forgotten when lock returns.
  assign lock_drop = !locked_s && (dg_cnt_q == DG_W'(DEGLITCH_LEN - 1));

  always_comb begin
    dg_cnt_d = dg_cnt_q;
    if (state_q == S_RUN) begin
      if (locked_s) begin
        dg_cnt_d = '0;
      end else if (!lock_drop) begin
        dg_cnt_d = dg_cnt_q + DG_W'(1);
      end
    end
    if (bus.force_relock || (state_d != state_q)) begin
      dg_cnt_d = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      dg_cnt_q <= '0;
    end else begin
      dg_cnt_q <= dg_cnt_d;
    end
  end
`else
  assign lock_drop = !locked_s;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stb_cnt_d = stb_cnt_q;
    loss_d    = loss_q;

    case (state_q)
      S_PLLRST: begin
        if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_WAIT: begin
        // Lock is checked first so a lock arriving on the timeout cycle wins.
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d = S_PLLRST;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_STABLE: begin
        // The WAIT cycle that saw lock counts as the first stable cycle.
        if (!locked_s) begin
          state_d = S_WAIT;
        end else if (stb_cnt_q == STB_W'(STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      default: begin
        if (lock_drop) begin
          state_d = S_WAIT;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
    endcase

    // A relock request overrides everything, including a simultaneous loss.
    if (bus.force_relock) begin
      state_d = S_PLLRST;
      loss_d  = loss_q;
    end

    // Every state entry (including a forced re-entry of PLLRST) restarts
    // the counters, so none of them can run past its limit.
    if (bus.force_relock || (state_d != state_q)) begin
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stb_cnt_d = (state_d == S_STABLE) ? STB_W'(1) : '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PLLRST;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      loss_q      <= loss_d;
      // Outputs are registered from the next state so they change on the
      // same edge as the state and sys_reset never passes through logic.
      pll_rst_q   <= (state_d == S_PLLRST);
      sys_reset_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign bus.pll_rst    = pll_rst_q;
  assign bus.sys_reset  = sys_reset_q;
  assign bus.ready      = ready_q;
  assign bus.state      = state_q;
  assign bus.loss_count = loss_q;

endmodule
